// File: rtl/button_debounce.sv
// Multi-channel button synchroniser and debouncer with clean level and press/release strobes.
// Optional long-press detection is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
    parameter longint CLOCK_HZ         = 24_000_000,
    parameter int     NUMBER_OF_INPUTS = 8,
    parameter int     DEBOUNCE_MS      = 10,
    parameter bit     INPUT_ACTIVE_LOW = 1'b1,
    parameter int     LONG_PRESS_MS    = 1000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUMBER_OF_INPUTS-1:0] button_in,
    output logic [NUMBER_OF_INPUTS-1:0] button_level,
    output logic [NUMBER_OF_INPUTS-1:0] button_pressed,
    output logic [NUMBER_OF_INPUTS-1:0] button_released,
    output logic [NUMBER_OF_INPUTS-1:0] button_long
);

    localparam longint DEBOUNCE_RAW    = CLOCK_HZ / 1000 * longint'(DEBOUNCE_MS);
    localparam longint DEBOUNCE_CYCLES = (DEBOUNCE_RAW < 1) ? 1 : DEBOUNCE_RAW;
    localparam int     DB_W            = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [NUMBER_OF_INPUTS-1:0] INACTIVE_PINS = {NUMBER_OF_INPUTS{INPUT_ACTIVE_LOW}};

    if (NUMBER_OF_INPUTS < 1 || DEBOUNCE_MS < 0 || LONG_PRESS_MS < 0) begin : g_bad_param
        $error("button_debounce: invalid parameter set");
    end

    logic [NUMBER_OF_INPUTS-1:0] sync1;
    logic [NUMBER_OF_INPUTS-1:0] sync2;
    logic [NUMBER_OF_INPUTS-1:0] raw;

    // Synchroniser resets to the idle pin level so reset release never looks like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INACTIVE_PINS;
            sync2 <= INACTIVE_PINS;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1, giving a true 2-stage chain.
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    assign raw = sync2 ^ INACTIVE_PINS;

    for (genvar ch = 0; ch < NUMBER_OF_INPUTS; ch++) begin : g_channel
        logic [DB_W-1:0] db_count;
        logic            level_q;
        logic            pressed_q;
        logic            released_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                db_count   <= '0;
                level_q    <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                // NOTE: strobes default low every cycle so they can never stretch past one clock.
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                if (raw[ch] == level_q) begin
                    db_count <= '0;
                end else if (db_count == DB_LAST) begin
                    db_count   <= '0;
                    level_q    <= raw[ch];
                    pressed_q  <= raw[ch];
                    released_q <= ~raw[ch];
                end else begin
                    db_count <= db_count + DB_W'(1);
                end
            end
        end

        assign button_level[ch]    = level_q;
        assign button_pressed[ch]  = pressed_q;
        assign button_released[ch] = released_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        localparam longint LONG_RAW    = CLOCK_HZ / 1000 * longint'(LONG_PRESS_MS);
        localparam longint LONG_CYCLES = (LONG_RAW < 1) ? 1 : LONG_RAW;
        localparam int     LG_W        = $clog2(LONG_CYCLES + 1);
        localparam logic [LG_W-1:0] LONG_MAX  = LG_W'(LONG_CYCLES);
        localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_CYCLES - 1);

        logic [LG_W-1:0] hold_count;
        logic            long_q;

        // Saturating at LONG_CYCLES is what suppresses repeats while the button stays held.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                hold_count <= '0;
                long_q     <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    hold_count <= '0;
                end else if (hold_count != LONG_MAX) begin
                    hold_count <= hold_count + LG_W'(1);
                    long_q     <= (hold_count == LONG_LAST);
                end
            end
        end

        assign button_long[ch] = long_q;
`else
        assign button_long[ch] = 1'b0;
`endif
    end

endmodule
